// File: rtl/jtag_ir_pkg.sv
// Shared constants for the JTAG instruction register: default opcodes,
// the BYPASS all-ones rule, the capture-value LSB pattern and select indices.
package jtag_ir_pkg;

    localparam int          DEF_IR_WIDTH    = 4;
    localparam logic [3:0]  DEF_CAPTURE_VAL = 4'b0001;
    localparam logic [3:0]  DEF_IDCODE_OP   = 4'b0010;
    localparam logic [3:0]  DEF_EXTEST_OP   = 4'b0000;
    localparam logic [3:0]  DEF_SAMPLE_OP   = 4'b0001;

    // BYPASS is every instruction bit set to this value.
    localparam logic        BYPASS_FILL     = 1'b1;

    // IEEE 1149.1 requires the two bits nearest TDO to capture as 01.
    localparam logic [1:0]  CAPTURE_LSBS    = 2'b01;

    // Bit positions of the one-hot select vector.
    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_IDCODE = 2'd1,
        SEL_EXTEST = 2'd2,
        SEL_SAMPLE = 2'd3
    } sel_idx_e;

    localparam int SEL_COUNT = 4;

endpackage

// File: rtl/jtag_ir_decoder.sv
// Combinational opcode -> one-hot data-register select. All-ones and any
// opcode not matching a defined instruction fall through to BYPASS.
module jtag_ir_decoder
    import jtag_ir_pkg::*;
#(
    parameter int                  IR_WIDTH  = DEF_IR_WIDTH,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP = DEF_IDCODE_OP,
    parameter logic [IR_WIDTH-1:0] EXTEST_OP = DEF_EXTEST_OP,
    parameter logic [IR_WIDTH-1:0] SAMPLE_OP = DEF_SAMPLE_OP
) (
    input  logic [IR_WIDTH-1:0]  opcode,
    output logic [SEL_COUNT-1:0] sel
);

    // BYPASS checked first so an all-ones opcode can never alias another op.
    always_comb begin
        sel = '0;
        if (opcode == {IR_WIDTH{BYPASS_FILL}})
            sel[SEL_BYPASS] = 1'b1;
        else if (opcode == IDCODE_OP)
            sel[SEL_IDCODE] = 1'b1;
        else if (opcode == EXTEST_OP)
            sel[SEL_EXTEST] = 1'b1;
        else if (opcode == SAMPLE_OP)
            sel[SEL_SAMPLE] = 1'b1;
        else
            sel[SEL_BYPASS] = 1'b1;
    end

endmodule

// File: rtl/jtag_instruction_register.sv
// N-bit JTAG instruction register: capture/shift/update/decode in the TCK domain.
// Optional feature macro JTAG_IR_PARITY_EN: adds an odd-parity bit at the TDO
// end of the shift stage and a sticky ParityErr output; bad loads are rejected.
module jtag_instruction_register
    import jtag_ir_pkg::*;
#(
    parameter int                  IR_WIDTH    = DEF_IR_WIDTH,
    parameter logic [IR_WIDTH-1:0] CAPTURE_VAL = DEF_CAPTURE_VAL,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP   = DEF_IDCODE_OP,
    parameter logic [IR_WIDTH-1:0] EXTEST_OP   = DEF_EXTEST_OP,
    parameter logic [IR_WIDTH-1:0] SAMPLE_OP   = DEF_SAMPLE_OP
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic                TestLogicRst,
    input  logic                CaptureIR,
    input  logic                ShiftIR,
    input  logic                UpdateIR,
    input  logic                TDI,
    output logic                TDO,
    output logic [IR_WIDTH-1:0] Instr,
`ifdef JTAG_IR_PARITY_EN
    output logic                ParityErr,
`endif
    output logic                SelBypass,
    output logic                SelIdcode,
    output logic                SelExtest,
    output logic                SelSample
);

    // Force the two TDO-side capture bits to 01 whatever the caller passes.
    localparam logic [IR_WIDTH-1:0] CAP_IR =
        (CAPTURE_VAL & ~IR_WIDTH'(3)) | IR_WIDTH'(CAPTURE_LSBS);

`ifdef JTAG_IR_PARITY_EN
    localparam int              SR_W   = IR_WIDTH + 1;
    // Parity bit sits at the LSB and captures as 0.
    localparam logic [SR_W-1:0] CAP_SR = {CAP_IR, 1'b0};
`else
    localparam int              SR_W   = IR_WIDTH;
    localparam logic [SR_W-1:0] CAP_SR = CAP_IR;
`endif

    logic [SR_W-1:0]      sr;
    logic [IR_WIDTH-1:0]  instr_q;
    logic [SEL_COUNT-1:0] sel_q;
    logic [SEL_COUNT-1:0] sel_nxt;
    logic [IR_WIDTH-1:0]  payload;
    logic [IR_WIDTH-1:0]  instr_nxt;
    logic                 rst;
    logic                 par_ok;

    assign rst     = !ResetN || TestLogicRst;
    assign payload = sr[SR_W-1:SR_W-IR_WIDTH];

`ifdef JTAG_IR_PARITY_EN
    // Odd parity over the whole stage, parity bit included.
    assign par_ok = ^sr;
`else
    assign par_ok = 1'b1;
`endif

    // Value headed for the instruction latch; decoded ahead so Sel* and Instr
    // are registered on the same edge.
    assign instr_nxt = rst ? IDCODE_OP : payload;

    jtag_ir_decoder #(
        .IR_WIDTH  (IR_WIDTH),
        .IDCODE_OP (IDCODE_OP),
        .EXTEST_OP (EXTEST_OP),
        .SAMPLE_OP (SAMPLE_OP)
    ) u_dec (
        .opcode (instr_nxt),
        .sel    (sel_nxt)
    );

    // Shift stage: reset > capture > shift > hold.
    always_ff @(posedge Clock) begin
        if (rst)
            sr <= CAP_SR;
        else if (CaptureIR)
            sr <= CAP_SR;
        else if (ShiftIR)
            sr <= {TDI, sr[SR_W-1:1]};
    end

    // Instruction latch and select lines: load on reset or accepted update,
    // using the shift stage as it stood before this edge.
    always_ff @(posedge Clock) begin
        if (rst) begin
            instr_q <= IDCODE_OP;
            sel_q   <= sel_nxt;
        end else if (UpdateIR && par_ok) begin
            instr_q <= payload;
            sel_q   <= sel_nxt;
        end
    end

`ifdef JTAG_IR_PARITY_EN
    // Sticky parity error: set by a rejected update, cleared by reset or a good one.
    always_ff @(posedge Clock) begin
        if (rst)
            ParityErr <= 1'b0;
        else if (UpdateIR)
            ParityErr <= !par_ok;
    end
`endif

    assign TDO       = sr[0];
    assign Instr     = instr_q;
    assign SelBypass = sel_q[SEL_BYPASS];
    assign SelIdcode = sel_q[SEL_IDCODE];
    assign SelExtest = sel_q[SEL_EXTEST];
    assign SelSample = sel_q[SEL_SAMPLE];

endmodule

// File: tb/tb_jtag_instruction_register.sv
// Directed + randomized bench for jtag_instruction_register (IR_WIDTH=4).
// Reference model keeps the shift stage as a bit queue (front = TDO end).
module tb_jtag_instruction_register;

    localparam int IRW = 4;
`ifdef JTAG_IR_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int SRW = IRW + PW;

    logic           Clock = 1'b0;
    logic           ResetN, TestLogicRst, CaptureIR, ShiftIR, UpdateIR, TDI;
    logic           TDO;
    logic [IRW-1:0] Instr;
    logic           SelBypass, SelIdcode, SelExtest, SelSample;
`ifdef JTAG_IR_PARITY_EN
    logic           ParityErr;
`endif

    jtag_instruction_register dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .TestLogicRst (TestLogicRst),
        .CaptureIR    (CaptureIR),
        .ShiftIR      (ShiftIR),
        .UpdateIR     (UpdateIR),
        .TDI          (TDI),
        .TDO          (TDO),
        .Instr        (Instr),
`ifdef JTAG_IR_PARITY_EN
        .ParityErr    (ParityErr),
`endif
        .SelBypass    (SelBypass),
        .SelIdcode    (SelIdcode),
        .SelExtest    (SelExtest),
        .SelSample    (SelSample)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit mq[$];
    int m_instr;
    bit m_perr;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_capture();
        int cap;
        cap = 1;                          // CAPTURE_VAL = 0001
        mq.delete();
        for (int i = 0; i < PW; i++) mq.push_back(1'b0);   // parity bit captures 0
        for (int i = 0; i < IRW; i++) mq.push_back(bit'((cap >> i) & 1));
    endtask

    function automatic int payload_of();
        int v = 0;
        for (int i = 0; i < IRW; i++) if (mq[PW + i]) v += (1 << i);
        return v;
    endfunction

    function automatic bit parity_ok();
        int ones = 0;
        if (PW == 0) return 1'b1;
        foreach (mq[i]) ones += int'(mq[i]);
        return (ones % 2) == 1;
    endfunction

    // Compare every output against the model.
    task automatic check_all(input string tag);
        int e_byp, e_id, e_ex, e_sa;
        e_id  = (m_instr == 2) ? 1 : 0;
        e_ex  = (m_instr == 0) ? 1 : 0;
        e_sa  = (m_instr == 1) ? 1 : 0;
        e_byp = (e_id + e_ex + e_sa == 0) ? 1 : 0;
        check({tag, ".tdo"},   int'(TDO),       int'(mq[0]));
        check({tag, ".instr"}, int'(Instr),     m_instr);
        check({tag, ".byp"},   int'(SelBypass), e_byp);
        check({tag, ".idc"},   int'(SelIdcode), e_id);
        check({tag, ".ext"},   int'(SelExtest), e_ex);
        check({tag, ".smp"},   int'(SelSample), e_sa);
        check({tag, ".onehot"},
              int'(SelBypass) + int'(SelIdcode) + int'(SelExtest) + int'(SelSample), 1);
`ifdef JTAG_IR_PARITY_EN
        check({tag, ".perr"},  int'(ParityErr), int'(m_perr));
`endif
    endtask

    // One TCK cycle: drive at negedge, model the edge, check at next negedge.
    task automatic cycle(input string tag, input bit rstn, input bit tlr,
                         input bit cap, input bit sh, input bit upd, input bit tdi);
        int old_pay;
        bit old_ok;
        ResetN = rstn; TestLogicRst = tlr; CaptureIR = cap;
        ShiftIR = sh; UpdateIR = upd; TDI = tdi;
        @(posedge Clock);
        old_pay = payload_of();
        old_ok  = parity_ok();
        if (!rstn || tlr) begin
            load_capture();
            m_instr = 2;
            m_perr  = 1'b0;
        end else begin
            if (upd) begin
                if (old_ok) begin m_instr = old_pay; m_perr = 1'b0; end
                else m_perr = 1'b1;
            end
            if (cap) load_capture();
            else if (sh) begin
                void'(mq.pop_front());
                mq.push_back(tdi);
            end
        end
        @(negedge Clock);
        check_all(tag);
    endtask

    // Shift an opcode in LSB first, preceded by a parity bit (good or bad) if enabled.
    task automatic shift_op(input string tag, input int op, input bit good);
        bit p;
        p = 1'b1;
        for (int i = 0; i < IRW; i++) p ^= bit'((op >> i) & 1);
        if (!good) p = ~p;
        if (PW == 1) cycle(tag, 1, 0, 0, 1, 0, p);
        for (int i = 0; i < IRW; i++) cycle(tag, 1, 0, 0, 1, 0, bit'((op >> i) & 1));
    endtask

    task automatic update(input string tag);
        cycle(tag, 1, 0, 0, 0, 1, 0);
    endtask

    initial begin
        ResetN = 1'b1; TestLogicRst = 1'b0; CaptureIR = 1'b0;
        ShiftIR = 1'b0; UpdateIR = 1'b0; TDI = 1'b0;
        m_instr = 0; m_perr = 1'b0;
        load_capture();
        @(negedge Clock);

        // 1. Reset
        cycle("reset", 0, 0, 0, 0, 0, 0);
        check("reset.instr_const", int'(Instr), 2);
        check("reset.idcode_const", int'(SelIdcode), 1);
        if (PW == 0) check("reset.tdo_const", int'(TDO), 1);

        // 2. Capture then shift zeros: TDO 1,0,0,0
        cycle("capture", 1, 0, 1, 0, 0, 0);
        check("cap.tdo_const", int'(TDO), 1);
        for (int i = 0; i < 4; i++) cycle("shift0", 1, 0, 0, 1, 0, 0);

        // 3. EXTEST
        shift_op("ld_extest", 0, 1'b1);
        update("upd_extest");
        check("extest.instr_const", int'(Instr), 0);
        check("extest.sel_const", int'(SelExtest), 1);

        // 4. Undefined and all-ones -> BYPASS
        shift_op("ld_1010", 4'b1010, 1'b1);
        update("upd_1010");
        check("undef.byp_const", int'(SelBypass), 1);
        shift_op("ld_1111", 4'b1111, 1'b1);
        update("upd_1111");
        check("ones.byp_const", int'(SelBypass), 1);

        // SAMPLE and IDCODE via update
        shift_op("ld_sample", 1, 1'b1);
        update("upd_sample");
        check("sample.sel_const", int'(SelSample), 1);

        // 5. Capture+Shift+Update together: latches pre-edge stage, stage captures
        shift_op("ld_0101", 4'b0101, 1'b1);
        cycle("cap_sh_upd", 1, 0, 1, 1, 1, 1);
        check("csu.instr_const", int'(Instr), 4'b0101);

        // Update with shift in the same cycle
        shift_op("ld_ext2", 0, 1'b1);
        cycle("sh_upd", 1, 0, 0, 1, 1, 1);
        check("shupd.instr_const", int'(Instr), 0);

        // TestLogicRst mid-shift discards partial data
        cycle("cap2", 1, 0, 1, 0, 0, 0);
        cycle("part0", 1, 0, 0, 1, 0, 1);
        cycle("part1", 1, 0, 0, 1, 0, 1);
        cycle("tlr", 1, 1, 1, 1, 1, 1);
        check("tlr.instr_const", int'(Instr), 2);
        update("upd_after_tlr");
        check("tlr.discard_const", int'(Instr), 1);

`ifdef JTAG_IR_PARITY_EN
        // 6. Parity: bad load rejected, good load accepted
        shift_op("ld_bad", 0, 1'b0);
        update("upd_bad");
        check("par.bad_instr_const", int'(Instr), 1);
        check("par.bad_err_const", int'(ParityErr), 1);
        shift_op("ld_good", 0, 1'b1);
        update("upd_good");
        check("par.good_instr_const", int'(Instr), 0);
        check("par.good_err_const", int'(ParityErr), 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit rstn, tlr;
            rstn = ($urandom_range(0, 39) != 0);
            tlr  = ($urandom_range(0, 39) == 0);
            cycle("rand", rstn, tlr,
                  bit'($urandom_range(0, 5) == 0),
                  bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 4) == 0),
                  bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
